// File: rtl/led_scan_pkg.sv
// rtl/led_scan_pkg.sv - shared motion-mode and direction constants for the LED scanner
package led_scan_pkg;

  localparam logic [1:0] MODE_BOUNCE  = 2'd0;
  localparam logic [1:0] MODE_WRAP_UP = 2'd1;
  localparam logic [1:0] MODE_WRAP_DN = 2'd2;
  localparam logic [1:0] MODE_FILL    = 2'd3;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/scan_prescaler.sv
// rtl/scan_prescaler.sv - step-rate prescaler; tick marks the last cycle of each DIV-cycle period
module scan_prescaler #(
  parameter int unsigned DIV = 5000000
) (
  input  logic CLK,
  input  logic CLR,
  input  logic en,
  output logic tick
);

  localparam logic [31:0] LAST = 32'(DIV - 1);

  logic [31:0] count;

  assign tick = en && (count == LAST);

  always_ff @(posedge CLK) begin
    if (CLR || !en || tick) begin
      count <= '0;
    end else begin
      count <= count + 32'd1;
    end
  end

endmodule

// File: rtl/led_scanner.sv
// rtl/led_scanner.sv - Knight Rider LED scanner with run/stop button and four motion modes
// Optional trailing LED in modes 0-2 is built when LED_TRAIL_EN is defined.
module led_scanner
  import led_scan_pkg::*;
#(
  parameter int          N_LEDS = 10,
  parameter int unsigned DIV    = 5000000
) (
  input  logic                      CLK,
  input  logic                      CLR,
  input  logic                      OnOff,
  input  logic [1:0]                MODE,
  output logic [N_LEDS-1:0]         LEDRArray,
  output logic [$clog2(N_LEDS)-1:0] POS,
  output logic                      DIR,
  output logic                      RUN
);

  localparam int            PW   = $clog2(N_LEDS);
  localparam logic [PW-1:0] LAST = PW'(N_LEDS - 1);
  localparam logic [PW-1:0] ONE  = PW'(1);

  logic          sync1, sync2, btn_prev;
  logic [1:0]    warm;
  logic          armed;
  logic          fall, tick;
  logic [PW-1:0] next_pos;
  logic          next_dir;

  // armed blocks a button held through CLR from looking like a fresh press
  assign fall = armed & btn_prev & ~sync2;

  scan_prescaler #(.DIV(DIV)) u_prescaler (
    .CLK  (CLK),
    .CLR  (CLR),
    .en   (RUN & ~fall),
    .tick (tick)
  );

  always_comb begin
    next_pos = POS;
    next_dir = DIR;
    case (MODE)
      MODE_WRAP_UP: begin
        next_dir = DIR_UP;
        next_pos = (POS == LAST) ? '0 : POS + ONE;
      end
      MODE_WRAP_DN: begin
        next_dir = DIR_DOWN;
        next_pos = (POS == '0) ? LAST : POS - ONE;
      end
      MODE_BOUNCE, MODE_FILL: begin
        if (DIR == DIR_UP && POS == LAST) begin
          next_dir = DIR_DOWN;
          next_pos = LAST - ONE;
        end else if (DIR == DIR_DOWN && POS == '0) begin
          next_dir = DIR_UP;
          next_pos = ONE;
        end else begin
          next_pos = (DIR == DIR_UP) ? POS + ONE : POS - ONE;
        end
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      sync1    <= 1'b1;
      sync2    <= 1'b1;
      btn_prev <= 1'b1;
      warm     <= 2'b00;
      armed    <= 1'b0;
      RUN      <= 1'b0;
      POS      <= '0;
      DIR      <= DIR_UP;
    end else begin
      sync1    <= OnOff;
      sync2    <= sync1;
      btn_prev <= sync2;
      warm     <= {warm[0], 1'b1};
      if (warm[1] && sync2) begin
        armed <= 1'b1;
      end
      // tick is already masked by fall, so a stop edge never advances POS
      if (fall) begin
        RUN <= ~RUN;
      end else if (tick) begin
        POS <= next_pos;
        DIR <= next_dir;
      end
    end
  end

`ifdef LED_TRAIL_EN
  logic [PW-1:0] prev;

  always_ff @(posedge CLK) begin
    if (CLR) begin
      prev <= '0;
    end else if (tick || (fall && !RUN)) begin
      prev <= POS;
    end
  end
`endif

  always_comb begin
    LEDRArray = '0;
    if (RUN) begin
      if (MODE == MODE_FILL) begin
        for (int i = 0; i < N_LEDS; i++) begin
          LEDRArray[i] = (PW'(i) <= POS);
        end
      end else begin
        LEDRArray[POS] = 1'b1;
`ifdef LED_TRAIL_EN
        LEDRArray[prev] = 1'b1;
`endif
      end
    end
  end

endmodule
